// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver: HUB75 dual-half panel scan driver with binary-code-modulated colour depth
// Ports: CLK_I clock, RST_N_I sync active-low reset, ENABLE_I run scan;
//   ADDR_O/RD_O/DATA_I frame memory read port ({row,col}; DATA_I valid one cycle after RD_O);
//   R0,G0,B0,R1,G1,B1 colour bits; ROW_O row address; CLK_O shift clock (panel samples on rise);
//   LATCH active-high latch; OE active-low output enable; FRAME_O pulse when row 0 plane 0 latches.
module hub75_bcm_driver #(
  parameter int COLS = 32,
  parameter int ROW_BITS = 4,
  parameter int DEPTH = 4,
  parameter int CLK_DIV = 2,
  parameter int BASE_ON = 8,
  localparam int COL_BITS = $clog2(COLS)
) (
  input  logic                         CLK_I,
  input  logic                         RST_N_I,
  input  logic                         ENABLE_I,
  output logic [ROW_BITS+COL_BITS-1:0] ADDR_O,
  output logic                         RD_O,
  input  logic [6*DEPTH-1:0]           DATA_I,
  output logic                         R0,
  output logic                         G0,
  output logic                         B0,
  output logic                         R1,
  output logic                         G1,
  output logic                         B1,
  output logic [ROW_BITS-1:0]          ROW_O,
  output logic                         CLK_O,
  output logic                         LATCH,
  output logic                         OE,
  output logic                         FRAME_O
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int CW = ROW_BITS + $clog2(BASE_ON) + DEPTH + 1;
  localparam logic [2:0] S_IDLE = 3'd0, S_PREFETCH = 3'd1, S_SHIFT = 3'd2, S_WAIT = 3'd3, S_LATCH1 = 3'd4, S_LATCH2 = 3'd5;
  logic [2:0] r_state;
  logic [ROW_BITS-1:0] r_row, r_row_o;
  logic [PW-1:0] r_plane;
  logic [COL_BITS-1:0] r_col;
  logic [DW-1:0] r_ph;
  logic r_hi, r_rd_d, r_stop;
  logic [5:0] r_buf, r_out;
  logic [CW-1:0] r_cnt;
  logic [DEPTH-1:0] w_ch [6];
  logic [5:0] w_pix, w_bits, w_colour;
  logic [COL_BITS-1:0] w_col_m1;
  logic w_last_ph, w_last_plane, w_load, w_rd;
  for (genvar c = 0; c < 6; c++) begin : g_ch
    assign w_ch[c] = DATA_I[c*DEPTH +: DEPTH];
    assign w_pix[c] = w_ch[c][r_plane];
  end
  assign w_col_m1 = r_col - COL_BITS'(1);
  assign w_last_ph = r_ph == DW'(CLK_DIV - 1);
  assign w_last_plane = r_plane == PW'(DEPTH - 1);
  assign w_load = r_state == S_SHIFT && !r_hi && r_ph == '0;
  // Next column is fetched on the first high-phase cycle; none after column 0.
  assign w_rd = r_state == S_PREFETCH || (r_state == S_SHIFT && r_hi && r_ph == '0 && r_col != '0);
  // Fetched bits are caught the cycle after the read so CLK_DIV > 1 still sees them at the next low phase.
  assign w_bits = r_rd_d ? w_pix : r_buf;
  // Bits appear at the start of the low phase so they are stable before CLK_O rises.
  assign w_colour = w_load ? w_bits : r_out;
  assign {B1, G1, R1, B0, G0, R0} = w_colour;
  assign RD_O = w_rd;
  assign ADDR_O = w_rd ? {r_row, (r_state == S_PREFETCH ? COL_BITS'(COLS - 1) : w_col_m1)} : '0;
  assign CLK_O = r_hi;
  assign LATCH = r_state == S_LATCH1;
  assign FRAME_O = LATCH && r_row == '0 && r_plane == '0;
  assign ROW_O = r_row_o;
  assign OE = !(r_cnt != '0 && r_state != S_LATCH1 && r_state != S_LATCH2);
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      r_state <= S_IDLE;
      r_row <= '0;
      r_row_o <= '0;
      r_plane <= '0;
      r_col <= '0;
      r_ph <= '0;
      r_hi <= 1'b0;
      r_rd_d <= 1'b0;
      r_stop <= 1'b0;
      r_buf <= '0;
      r_out <= '0;
      r_cnt <= '0;
    end else begin
      r_rd_d <= w_rd;
      r_buf <= w_bits;
      if (w_load) r_out <= w_bits;
      r_cnt <= r_state == S_LATCH2 ? CW'(BASE_ON) << r_plane : (r_cnt != '0 ? r_cnt - CW'(1) : r_cnt);
      case (r_state)
        S_IDLE: if (ENABLE_I) r_state <= S_PREFETCH;
        S_PREFETCH: begin
          r_col <= COL_BITS'(COLS - 1);
          r_ph <= '0;
          r_hi <= 1'b0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_ph <= w_last_ph ? '0 : r_ph + DW'(1);
          if (w_last_ph) begin
            r_hi <= !r_hi;
            if (r_hi) r_col <= w_col_m1;
            if (r_hi && r_col == '0) r_state <= S_WAIT;
          end
        end
        // Also used to let the final plane finish displaying after ENABLE_I drops.
        S_WAIT: if (r_cnt == '0) begin
          r_state <= r_stop ? S_IDLE : S_LATCH1;
          if (r_stop) begin
            r_stop <= 1'b0;
            r_row <= '0;
            r_plane <= '0;
          end
        end
        S_LATCH1: begin
          r_row_o <= r_row;
          r_state <= S_LATCH2;
        end
        S_LATCH2: begin
          r_plane <= w_last_plane ? '0 : r_plane + PW'(1);
          if (w_last_plane) r_row <= r_row + ROW_BITS'(1);
          r_stop <= !ENABLE_I;
          r_state <= ENABLE_I ? S_PREFETCH : S_WAIT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hub75_bcm_driver.sv
// tb_hub75_bcm_driver: self-checking bench for hub75_bcm_driver
module tb_hub75_bcm_driver;
  localparam int COLS = 4, DEPTH = 2, AW = 3, DW = 12;
  typedef struct {int col; logic [1:0] r0; logic p0; logic p1;} vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] mem [8];
  vec_t vecs [4];
  logic a_rst_n = 1'b0, a_en = 1'b0, b_rst_n = 1'b0, b_en = 1'b0;
  logic [AW-1:0] a_addr, b_addr;
  logic a_rd, b_rd, a_clko, b_clko, a_latch, b_latch, a_oe, b_oe, a_frame, b_frame;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic [5:0] a_rgb, b_rgb;
  logic [0:0] a_row, b_row;
  hub75_bcm_driver #(.COLS(4), .ROW_BITS(1), .DEPTH(2), .CLK_DIV(1), .BASE_ON(4)) dut_a (
    .CLK_I(clk), .RST_N_I(a_rst_n), .ENABLE_I(a_en), .ADDR_O(a_addr), .RD_O(a_rd), .DATA_I(a_data),
    .R0(a_rgb[0]), .G0(a_rgb[1]), .B0(a_rgb[2]), .R1(a_rgb[3]), .G1(a_rgb[4]), .B1(a_rgb[5]),
    .ROW_O(a_row), .CLK_O(a_clko), .LATCH(a_latch), .OE(a_oe), .FRAME_O(a_frame));
  hub75_bcm_driver #(.COLS(4), .ROW_BITS(1), .DEPTH(2), .CLK_DIV(1), .BASE_ON(64)) dut_b (
    .CLK_I(clk), .RST_N_I(b_rst_n), .ENABLE_I(b_en), .ADDR_O(b_addr), .RD_O(b_rd), .DATA_I(b_data),
    .R0(b_rgb[0]), .G0(b_rgb[1]), .B0(b_rgb[2]), .R1(b_rgb[3]), .G1(b_rgb[4]), .B1(b_rgb[5]),
    .ROW_O(b_row), .CLK_O(b_clko), .LATCH(b_latch), .OE(b_oe), .FRAME_O(b_frame));
  // Frame memory: data only valid the cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    a_data <= a_rd ? mem[a_addr] : DW'($urandom);
    b_data <= b_rd ? mem[b_addr] : DW'($urandom);
  end
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic logic [5:0] colour_of(input logic [DW-1:0] w, input int p);
    logic [5:0] e;
    for (int ch = 0; ch < 6; ch++) e[ch] = w[ch*DEPTH + p];
    return e;
  endfunction
  // Scoreboard monitor for DUT A
  logic mon_a = 1'b0, prev_clko_a = 1'b0, prev_lat_a = 1'b0;
  logic [5:0] q_col [$];
  int q_addr [$], q_oe_a [$];
  int run_a = 0, rises_a = 0, nlat_a = 0, nrise_a = 0;
  logic rise_r0 [8];
  always @(negedge clk) begin
    if (mon_a) begin
      if (a_rd && q_addr.size() > 0) chk("read_addr", a_addr, q_addr.pop_front());
      if (a_clko && !prev_clko_a) begin
        rises_a++;
        if (nrise_a < 8) rise_r0[nrise_a] = a_rgb[0];
        nrise_a++;
        if (q_col.size() > 0) chk("colour_at_rise", a_rgb, q_col.pop_front());
      end
      if (!a_oe) run_a++;
      else if (run_a > 0) begin
        if (q_oe_a.size() > 0) chk("oe_low_run", run_a, q_oe_a.pop_front());
        run_a = 0;
      end
      if (prev_lat_a) begin
        chk("latch_width", a_latch, 0);
        chk("oe_after_latch", a_oe, 1);
        chk("row_after_latch", a_row, ((nlat_a - 1) / DEPTH) % 2);
      end
      if (a_latch) begin
        chk("oe_in_latch", a_oe, 1);
        chk("frame_in_latch", a_frame, int'(nlat_a % 4 == 0));
        chk("rises_per_plane", rises_a, COLS);
        rises_a = 0;
        nlat_a++;
      end else chk("frame_outside_latch", a_frame, 0);
    end
    prev_clko_a = a_clko;
    prev_lat_a = mon_a && a_latch;
  end
  // Monitor for DUT B (long display, shift finishes first)
  logic mon_b = 1'b0, prev_clko_b = 1'b0;
  int q_oe_b [$];
  int run_b = 0, rises_b = 0;
  always @(negedge clk) begin
    if (mon_b) begin
      if (b_clko && !prev_clko_b) rises_b++;
      if (!b_oe) run_b++;
      else if (run_b > 0) begin
        if (q_oe_b.size() > 0) chk("b_oe_low_run", run_b, q_oe_b.pop_front());
        run_b = 0;
      end
      if (b_latch) begin
        chk("b_oe_in_latch", b_oe, 1);
        chk("b_rises_per_plane", rises_b, COLS);
        rises_b = 0;
      end
    end
    prev_clko_b = b_clko;
  end
  task automatic chk_reset_values(input string tag);
    chk({tag, "_oe"}, a_oe, 1);
    chk({tag, "_latch"}, a_latch, 0);
    chk({tag, "_clko"}, a_clko, 0);
    chk({tag, "_row"}, a_row, 0);
    chk({tag, "_rgb"}, a_rgb, 0);
    chk({tag, "_rd"}, a_rd, 0);
    chk({tag, "_addr"}, a_addr, 0);
    chk({tag, "_frame"}, a_frame, 0);
  endtask
  initial begin
    int lats, rises, oe_low, rd_after;
    logic seen, prev;
    vecs = '{'{3, 2'b01, 1'b1, 1'b0}, '{2, 2'b10, 1'b0, 1'b1}, '{1, 2'b11, 1'b1, 1'b1}, '{0, 2'b00, 1'b0, 1'b0}};
    for (int a = 0; a < 8; a++) mem[a] = 12'hA5C ^ DW'(a * 12'h1B3);
    for (int i = 0; i < 4; i++) mem[vecs[i].col][1:0] = vecs[i].r0;
    for (int i = 0; i < 8; i++) rise_r0[i] = 1'bx;
    for (int k = 0; k < 8; k++)
      for (int c = COLS - 1; c >= 0; c--) begin
        q_addr.push_back(((k / 2) % 2) * COLS + c);
        q_col.push_back(colour_of(mem[((k / 2) % 2) * COLS + c], k % 2));
      end
    for (int j = 0; j < 7; j++) q_oe_a.push_back(4 << (j % 2));
    for (int j = 0; j < 4; j++) q_oe_b.push_back(64 << (j % 2));
    // Reset held with ENABLE_I high
    a_en = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    // Free-run scan: data, BCM timing, row sequence, frame pulses
    mon_a = 1'b1;
    a_rst_n = 1'b1;
    for (int i = 0; i < 600 && (q_col.size() > 0 || q_oe_a.size() > 0 || q_addr.size() > 0); i++) @(negedge clk);
    chk("colour_queue_drained", q_col.size(), 0);
    chk("addr_queue_drained", q_addr.size(), 0);
    chk("oe_queue_drained", q_oe_a.size(), 0);
    for (int i = 0; i < 4; i++) begin
      chk("table_r0_plane0", int'(rise_r0[3 - vecs[i].col] === vecs[i].p0), 1);
      chk("table_r0_plane1", int'(rise_r0[7 - vecs[i].col] === vecs[i].p1), 1);
    end
    mon_a = 1'b0;
    // ENABLE_I dropped mid-shift: plane completes, displays, then idles
    a_rst_n = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1;
    for (int i = 0; i < 100 && !a_latch; i++) @(negedge clk);
    chk("ctl_first_latch_seen", a_latch, 1);
    for (int i = 0; i < 20 && !a_clko; i++) @(negedge clk);
    chk("ctl_shift_started", a_clko, 1);
    a_en = 1'b0;
    lats = 0; rises = 0; oe_low = 0; rd_after = 0; seen = 1'b0; prev = a_clko;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (a_clko && !prev) rises++;
      prev = a_clko;
      if (a_latch) begin
        lats++;
        seen = 1'b1;
        chk("ctl_oe_in_latch", a_oe, 1);
      end else if (seen) begin
        if (!a_oe) oe_low++;
        if (a_rd) rd_after++;
      end
    end
    chk("ctl_remaining_rises", rises, 3);
    chk("ctl_latches", lats, 1);
    chk("ctl_oe_low_plane1", oe_low, 8);
    chk("ctl_no_reads_after", rd_after, 0);
    chk("ctl_idle_oe", a_oe, 1);
    // Restart from IDLE begins at row 0, last column
    a_en = 1'b1;
    for (int i = 0; i < 10 && !a_rd; i++) @(negedge clk);
    chk("restart_rd", a_rd, 1);
    chk("restart_addr", a_addr, 3);
    // Reset in the middle of row 1 display/shift
    lats = 0;
    for (int i = 0; i < 200 && lats < 3; i++) begin
      @(negedge clk);
      if (a_latch) lats++;
    end
    chk("mid_latches_seen", lats, 3);
    for (int i = 0; i < 20 && !a_clko; i++) @(negedge clk);
    chk("mid_row_before_reset", a_row, 1);
    a_rst_n = 1'b0;
    @(negedge clk);
    chk_reset_values("midreset");
    a_rst_n = 1'b1;
    for (int i = 0; i < 10 && !a_rd; i++) @(negedge clk);
    chk("midreset_restart_rd", a_rd, 1);
    chk("midreset_restart_addr", a_addr, 3);
    a_en = 1'b0;
    // Display-limited timing: shift finishes early and waits
    mon_b = 1'b1;
    b_en = 1'b1;
    b_rst_n = 1'b1;
    for (int i = 0; i < 1500 && q_oe_b.size() > 0; i++) @(negedge clk);
    chk("b_oe_queue_drained", q_oe_b.size(), 0);
    mon_b = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
